adder_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed 6-bit combinational adder: WIDTH-bit add/subtract with registered carry chain split over STAGES pipeline segments.
- Valid/ready handshake on both sides, backpressure, signed-overflow flag.
- Used in datapath blocks that need one result per cycle at WIDTH values where a single-cycle ripple carry misses timing.

---
 rtl/adder_pipe.sv | 87 ++++++++
 tb/tb_adder_pipe.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/adder_pipe.sv
// adder_pipe: WIDTH-bit add/subtract with the carry chain split over STAGES registered segments
module adder_pipe #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             ovf
);
  localparam int CW = (WIDTH + STAGES - 1) / STAGES;
  localparam int L  = STAGES - 1;
  logic w_adv;
  assign w_adv    = ~(out_valid & ~out_ready);
  assign in_ready = w_adv;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int P = k * CW < WIDTH ? k * CW : WIDTH;
    localparam int H = (k + 1) * CW < WIDTH ? (k + 1) * CW : WIDTH;
    localparam int N = H - P;
    localparam int U = WIDTH - H;
    logic         w_vi, w_ci, w_oi, w_subi, w_c, w_o;
    logic [H-1:0] w_s;
    logic         r_v, r_c, r_o, r_sub;
    logic [H-1:0] r_s;
    if (k == 0) begin : g_in
      assign {w_vi, w_ci, w_oi, w_subi} = {in_valid, sub, 1'b0, sub};
    end else begin : g_pr
      assign {w_vi, w_ci, w_oi, w_subi} = {g_st[k-1].r_v, g_st[k-1].r_c, g_st[k-1].r_o, g_st[k-1].r_sub};
    end
    if (N == 0) begin : g_pass
      assign {w_c, w_o, w_s} = {w_ci, w_oi, g_st[k-1].r_s};
    end else begin : g_add
      logic [WIDTH-P-1:0] w_a, w_b;
      logic [N:0]         w_t;
      if (k == 0) begin : g_op
        assign w_a = a;
        assign w_b = sub ? ~b : b;
        assign w_s = w_t[N-1:0];
      end else begin : g_op
        assign w_a = g_st[k-1].g_add.g_hi.r_a;
        assign w_b = g_st[k-1].g_add.g_hi.r_b;
        assign w_s = {w_t[N-1:0], g_st[k-1].r_s};
      end
      assign w_t = {1'b0, w_a[N-1:0]} + {1'b0, w_b[N-1:0]} + {{N{1'b0}}, w_ci};
      assign w_c = w_t[N];
      if (U > 0) begin : g_hi
        logic [U-1:0] r_a, r_b;
        assign w_o = w_oi;
        always_ff @(posedge clk)
          if (rst) begin
            r_a <= '0;
            r_b <= '0;
          end else if (w_adv) begin
            r_a <= w_a[WIDTH-P-1:N];
            r_b <= w_b[WIDTH-P-1:N];
          end
      end else begin : g_top
        // carry into the MSB recovered from sum^a^b, xored with the carry out
        assign w_o = w_oi ^ w_t[N-1] ^ w_a[N-1] ^ w_b[N-1] ^ w_t[N];
      end
    end
    always_ff @(posedge clk)
      if (rst) begin
        r_v   <= 1'b0;
        r_c   <= 1'b0;
        r_o   <= 1'b0;
        r_sub <= 1'b0;
        r_s   <= '0;
      end else if (w_adv) begin
        r_v   <= w_vi;
        r_c   <= w_c;
        r_o   <= w_o;
        r_sub <= w_subi;
        r_s   <= w_s;
      end
  end
  assign out_valid = g_st[L].r_v;
  assign sum       = {g_st[L].r_c ^ g_st[L].r_sub, g_st[L].r_s};
  assign ovf       = g_st[L].r_o;
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: directed and random checks of adder_pipe at 6/2 and 13/{1,4,13} against a scoreboard
module tb_adder_pipe;
  logic clk = 0, rst = 1, iv = 0, sb = 0, ordy = 1, done = 0;
  logic [12:0] av = 0, bv = 0;
  int n_vec = 0, n_err = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string tag, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  function automatic int model(int w, int x, int y, bit s);
    int sx = x >= (1 << (w - 1)) ? x - (1 << w) : x;
    int sy = y >= (1 << (w - 1)) ? y - (1 << w) : y;
    int r  = s ? sx - sy : sx + sy;
    int u  = (s ? x - y : x + y) & ((1 << (w + 1)) - 1);
    bit o  = r > (1 << (w - 1)) - 1 || r < -(1 << (w - 1));
    return u | (int'(o) << (w + 1));
  endfunction
  for (genvar i = 0; i < 4; i++) begin : g_u
    localparam int W = i == 0 ? 6 : 13;
    localparam int S = i == 0 ? 2 : i == 1 ? 1 : i == 2 ? 4 : 13;
    logic rdy, ov, of;
    logic [W:0] sm;
    int q_e[$], q_t[$], q_s[$];
    int stl = 0;
    adder_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv), .in_ready(rdy), .a(av[W-1:0]), .b(bv[W-1:0]), .sub(sb),
      .out_valid(ov), .out_ready(ordy), .sum(sm), .ovf(of)
    );
    always @(negedge clk)
      if (rst) begin
        q_e.delete();
        q_t.delete();
        q_s.delete();
      end else begin
        if (ov) begin
          if (q_e.size() == 0) check($sformatf("stale%0d", i), int'(ov), 0);
          else begin
            check($sformatf("res%0d", i), int'({of, sm}), q_e[0]);
            if (ordy) begin
              check($sformatf("lat%0d", i), cyc - q_t[0] - (stl - q_s[0]), S);
              void'(q_e.pop_front());
              void'(q_t.pop_front());
              void'(q_s.pop_front());
            end
          end
        end
        if (iv && rdy) begin
          q_e.push_back(model(W, int'(av[W-1:0]), int'(bv[W-1:0]), sb));
          q_t.push_back(cyc);
          q_s.push_back(stl);
        end
        if (ov && !ordy) stl++;
      end
    always @(posedge done) check($sformatf("drain%0d", i), q_e.size(), 0);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  int ea[3] = '{3, 10, 8};
  int eb[3] = '{5, 7, 3};
  int es[3] = '{8, 17, 11};
  int ta[6] = '{63, 31, 32, 8, 3, 31};
  int tb[6] = '{63, 1, 32, 3, 5, 32};
  int tu[6] = '{0, 0, 0, 1, 1, 1};
  int ts[6] = '{126, 32, 64, 5, 126, 127};
  int to[6] = '{0, 1, 1, 0, 0, 1};
  initial begin
    repeat (3) tick;
    check("rst_v", int'(g_u[0].ov), 0);
    check("rst_s", int'(g_u[0].sm), 0);
    check("rst_o", int'(g_u[0].of), 0);
    rst = 0;
    #1;
    check("rst_rdy", int'(g_u[0].rdy), 1);
    for (int k = 0; k < 6; k++) begin
      iv = k < 3;
      if (k < 3) begin
        av = 13'(ea[k]);
        bv = 13'(eb[k]);
      end
      check("t1_v", int'(g_u[0].ov), int'(k >= 2 && k <= 4));
      if (k >= 2 && k <= 4) begin
        check("t1_s", int'(g_u[0].sm), es[k-2]);
        check("t1_o", int'(g_u[0].of), 0);
      end
      tick;
    end
    for (int j = 0; j < 6; j++) begin
      iv = 1;
      av = 13'(ta[j]);
      bv = 13'(tb[j]);
      sb = tu[j][0];
      tick;
      iv = 0;
      tick;
      check("t2_v", int'(g_u[0].ov), 1);
      check("t2_s", int'(g_u[0].sm), ts[j]);
      check("t2_o", int'(g_u[0].of), to[j]);
    end
    tick;
    ordy = 0;
    sb = 0;
    iv = 1;
    for (int k = 0; k < 2; k++) begin
      av = 13'(ea[k]);
      bv = 13'(eb[k]);
      #1;
      check("bp_rdy", int'(g_u[0].rdy), 1);
      tick;
    end
    av = 13'(ea[2]);
    bv = 13'(eb[2]);
    for (int k = 0; k < 4; k++) begin
      check("bp_hold_rdy", int'(g_u[0].rdy), 0);
      check("bp_hold_v", int'(g_u[0].ov), 1);
      check("bp_hold_s", int'(g_u[0].sm), 8);
      if (k < 3) tick;
    end
    ordy = 1;
    #1;
    check("bp_rel_rdy", int'(g_u[0].rdy), 1);
    tick;
    iv = 0;
    check("bp_r1", int'(g_u[0].sm), 17);
    tick;
    check("bp_r2", int'(g_u[0].sm), 11);
    tick;
    check("bp_end", int'(g_u[0].ov), 0);
    iv = 1;
    av = 1;
    bv = 2;
    tick;
    av = 4;
    bv = 4;
    tick;
    rst = 1;
    tick;
    check("mr_v", int'(g_u[0].ov), 0);
    check("mr_s", int'(g_u[0].sm), 0);
    check("mr_o", int'(g_u[0].of), 0);
    rst = 0;
    iv = 0;
    for (int k = 0; k < 15; k++) begin
      check("mr_idle0", int'(g_u[0].ov), 0);
      check("mr_idle3", int'(g_u[3].ov), 0);
      tick;
    end
    for (int k = 0; k < 3000; k++) begin
      iv = $urandom_range(0, 3) != 0;
      av = 13'($urandom);
      bv = 13'($urandom);
      sb = 1'($urandom);
      ordy = $urandom_range(0, 3) != 0;
      tick;
    end
    iv = 0;
    ordy = 1;
    repeat (30) tick;
    done = 1;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
